bootloader_wb_loader: RTL

BOOTLOADER_WB_LOADER -- requirements
Module: bootloader_wb_loader

---
 rtl/bootloader_wb_loader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bootloader_wb_loader.sv
// SD/SPI-fed boot loader: parses block/length headers and streams data bytes into Wishbone RAM
// writes while the CPU is held in reset. Define BOOTLOADER_CHECKSUM_EN for the per-block sum trailer.
module bootloader_wb_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_SHIFT = 9,
  parameter int BYTE_ORDER  = 0,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_spi_start,
  input  logic                    i_spi_comm,
  input  logic                    i_spi_eof,
  input  logic                    i_spi_done,
  input  logic [7:0]              i_spi_data,
  output logic                    o_spi_byte,
  output logic                    o_cpu_rst,
  output logic                    o_mux,
  output logic                    o_ram_cyc,
  output logic                    o_ram_stb,
  output logic                    o_ram_we,
  output logic [DATA_WIDTH/8-1:0] o_ram_sel,
  output logic [DATA_WIDTH-1:0]   o_ram_data,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  input  logic                    i_ram_ack,
  output logic                    o_done,
  output logic                    o_error,
  output logic [3:0]              o_state
);
  localparam int BPW    = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BPW);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT_BLOCK = 4'd1,
    S_HDR_BLOCK  = 4'd2,
    S_WAIT_LEN   = 4'd3,
    S_HDR_LEN    = 4'd4,
    S_WAIT_DATA  = 4'd5,
    S_DATA       = 4'd6,
    S_WRITE      = 4'd7,
`ifdef BOOTLOADER_CHECKSUM_EN
    S_CHECK      = 4'd8,
`endif
    S_ERROR      = 4'd9
  } state_t;

  state_t                r_state, w_next, w_after_blk;
  logic [31:0]           r_blk, r_len, r_cnt;
  logic [1:0]            r_hdr_cnt;
  logic [LANE_W-1:0]     r_lane, w_lane;
  logic [DATA_WIDTH-1:0] r_word;
  logic [BPW-1:0]        r_sel;
  logic [ADDR_WIDTH-1:0] r_widx, w_addr;
  logic [TO_W-1:0]       r_ack_cnt;
  logic                  r_gap, r_done, r_error;
  logic                  w_fetch, w_take, w_last_hdr, w_word_full, w_timeout, w_set_err;

`ifdef BOOTLOADER_CHECKSUM_EN
  logic [31:0] r_sum, r_trl;
  logic        w_sum_ok;
  assign w_sum_ok    = ({r_trl[23:0], i_spi_data} == r_sum);
  assign w_after_blk = S_CHECK;
  assign w_fetch     = (r_state == S_HDR_BLOCK) || (r_state == S_HDR_LEN) ||
                       (r_state == S_DATA) || (r_state == S_CHECK);
`else
  assign w_after_blk = S_WAIT_BLOCK;
  assign w_fetch     = (r_state == S_HDR_BLOCK) || (r_state == S_HDR_LEN) || (r_state == S_DATA);
`endif

  // Handshakes: o_spi_byte low requests a byte, which is taken on the first edge with i_spi_done
  // high, after which the request lifts for one cycle; Wishbone cyc/stb/we hold until the ack edge.
  assign w_take      = w_fetch && !r_gap && i_spi_done;
  assign w_last_hdr  = (r_hdr_cnt == 2'd3);
  assign w_word_full = (r_lane == LANE_W'(BPW - 1)) || ((r_cnt + 32'd1) == r_len);
  assign w_timeout   = (r_ack_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign w_lane      = (BYTE_ORDER != 0) ? r_lane : (LANE_W'(BPW - 1) - r_lane);
  assign w_addr      = (ADDR_WIDTH'(r_blk) << BLOCK_SHIFT) + (r_widx << LANE_W);

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      S_IDLE:       if (i_spi_start) w_next = S_WAIT_BLOCK;
      S_WAIT_BLOCK: begin
        if (i_spi_eof)       w_next = S_IDLE;
        else if (i_spi_comm) w_next = S_HDR_BLOCK;
      end
      S_HDR_BLOCK:  if (w_take && w_last_hdr) w_next = S_WAIT_LEN;
      S_WAIT_LEN:   if (i_spi_comm) w_next = S_HDR_LEN;
      S_HDR_LEN:    if (w_take && w_last_hdr) w_next = S_WAIT_DATA;
      S_WAIT_DATA:  if (i_spi_comm) w_next = (r_len == 32'd0) ? w_after_blk : S_DATA;
      S_DATA:       if (w_take && w_word_full) w_next = S_WRITE;
      S_WRITE: begin
        if (i_ram_ack) begin
          w_next = (r_cnt == r_len) ? w_after_blk : S_DATA;
        end else if (w_timeout) begin
          w_next    = S_ERROR;
          w_set_err = 1'b1;
        end
      end
`ifdef BOOTLOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_take && w_last_hdr) begin
          if (w_sum_ok) begin
            w_next = S_WAIT_BLOCK;
          end else begin
            w_next    = S_ERROR;
            w_set_err = 1'b1;
          end
        end
      end
`endif
      S_ERROR:      if (i_spi_start) w_next = S_WAIT_BLOCK;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_blk     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_hdr_cnt <= '0;
      r_lane    <= '0;
      r_word    <= '0;
      r_sel     <= '0;
      r_widx    <= '0;
      r_ack_cnt <= '0;
      r_gap     <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
      r_sum     <= '0;
      r_trl     <= '0;
`endif
    end else begin
      r_state   <= w_next;
      r_gap     <= w_take;
      r_done    <= (r_state == S_WAIT_BLOCK) && i_spi_eof;
      r_ack_cnt <= (r_state == S_WRITE) ? r_ack_cnt + 1'b1 : '0;
      if (w_set_err) r_error <= 1'b1;
      else if (i_spi_start && ((r_state == S_IDLE) || (r_state == S_ERROR))) r_error <= 1'b0;

      case (r_state)
        S_IDLE, S_ERROR: begin
          if (i_spi_start) begin
            r_blk <= '0;
            r_len <= '0;
          end
        end
        // Every block starts with a fresh word, index, byte count and sum.
        S_WAIT_BLOCK: begin
          r_cnt     <= '0;
          r_hdr_cnt <= '0;
          r_lane    <= '0;
          r_word    <= '0;
          r_sel     <= '0;
          r_widx    <= '0;
`ifdef BOOTLOADER_CHECKSUM_EN
          r_sum     <= '0;
`endif
        end
        S_HDR_BLOCK: begin
          if (w_take) begin
            r_blk     <= {r_blk[23:0], i_spi_data};
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
          end
        end
        S_HDR_LEN: begin
          if (w_take) begin
            r_len     <= {r_len[23:0], i_spi_data};
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (w_take) begin
            r_word[{w_lane, 3'b000} +: 8] <= i_spi_data;
            r_sel[w_lane]                 <= 1'b1;
            r_lane                        <= r_lane + 1'b1;
            r_cnt                         <= r_cnt + 32'd1;
`ifdef BOOTLOADER_CHECKSUM_EN
            r_sum                         <= r_sum + {24'd0, i_spi_data};
`endif
          end
        end
        S_WRITE: begin
          if (i_ram_ack) begin
            r_widx <= r_widx + 1'b1;
            r_lane <= '0;
            r_word <= '0;
            r_sel  <= '0;
          end
        end
`ifdef BOOTLOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_take) begin
            r_trl     <= {r_trl[23:0], i_spi_data};
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_mux      = (r_state != S_IDLE);
  assign o_cpu_rst  = (r_state != S_IDLE);
  assign o_spi_byte = !(w_fetch && !r_gap);
  assign o_ram_cyc  = (r_state == S_WRITE);
  assign o_ram_stb  = (r_state == S_WRITE);
  assign o_ram_we   = (r_state == S_WRITE);
  assign o_ram_sel  = (r_state == S_WRITE) ? r_sel : '0;
  assign o_ram_data = r_word;
  assign o_ram_addr = w_addr;
  assign o_done     = r_done;
  assign o_error    = r_error;
endmodule
